// File: rtl/sort_result_streamer_if.sv
// rtl/sort_result_streamer_if.sv - output word stream of sort_result_streamer
interface sort_result_streamer_if #(
   parameter int N     = 6,
   parameter int WIDTH = 8
);
   localparam int IW = $clog2(N);

   logic [WIDTH-1:0] out_data;
   logic [IW-1:0]    out_index;
   logic             out_valid;
   logic             out_last;
   logic             out_ready;

   modport master (
      output out_data,
      output out_index,
      output out_valid,
      output out_last,
      input  out_ready
   );

   modport slave (
      input  out_data,
      input  out_index,
      input  out_valid,
      input  out_last,
      output out_ready
   );
endinterface

// File: rtl/sort_result_streamer.sv
// rtl/sort_result_streamer.sv - captures a sorted frame on done and streams it word by word
module sort_result_streamer #(
   parameter int N          = 6,
   parameter int WIDTH      = 8,
   parameter bit DESCENDING = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  done_in,
   input  logic [WIDTH-1:0]      data_sorted_in [N],
   sort_result_streamer_if.master stream,
   output logic                  busy,
   output logic                  overrun,
   input  logic                  clear_overrun
);
   localparam int IW = $clog2(N);
   localparam logic [IW-1:0] FIRST_IDX = DESCENDING ? IW'(N - 1) : '0;
   localparam logic [IW-1:0] LAST_IDX  = DESCENDING ? '0 : IW'(N - 1);

   typedef enum logic {IDLE, STREAM} state_t;

   state_t           state_q, state_d;
   logic             done_q;
   logic [WIDTH-1:0] frame_q [N];
   logic [IW-1:0]    idx_q, idx_d;
   logic             overrun_q;
   logic             load;
   logic             set_ovr;
   logic             cap_ev;
   logic             streaming;
   logic             at_last;
   logic             xfer;

   assign cap_ev    = done_in & ~done_q;
   assign streaming = (state_q == STREAM);
   assign at_last   = (idx_q == LAST_IDX);
   assign xfer      = streaming & stream.out_ready;

   // Outputs decode registered state only; nothing combinational from out_ready or done_in.
   always_comb begin
      stream.out_valid = streaming;
      stream.out_last  = streaming & at_last;
      stream.out_index = streaming ? idx_q : '0;
      stream.out_data  = streaming ? frame_q[idx_q] : '0;
      busy             = streaming;
      overrun          = overrun_q;
   end

   // Next state: a capture on the final transfer chains straight into the next frame.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      load    = 1'b0;
      set_ovr = 1'b0;
      case (state_q)
         IDLE: begin
            if (cap_ev) begin
               load    = 1'b1;
               idx_d   = FIRST_IDX;
               state_d = STREAM;
            end
         end
         STREAM: begin
            if (xfer && at_last) begin
               if (cap_ev) begin
                  load  = 1'b1;
                  idx_d = FIRST_IDX;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               if (xfer) begin
                  idx_d = DESCENDING ? idx_q - IW'(1) : idx_q + IW'(1);
               end
               if (cap_ev) begin
                  set_ovr = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, capture buffer, edge detector and sticky overrun.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         done_q    <= 1'b0;
         idx_q     <= '0;
         overrun_q <= 1'b0;
         for (int i = 0; i < N; i++) begin
            frame_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         done_q  <= done_in;
         idx_q   <= idx_d;
         if (load) begin
            for (int i = 0; i < N; i++) begin
               frame_q[i] <= data_sorted_in[i];
            end
         end
         if (set_ovr) begin
            overrun_q <= 1'b1;
         end else if (clear_overrun) begin
            overrun_q <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_sort_result_streamer.sv
// tb/tb_sort_result_streamer.sv - directed scoreboard bench for sort_result_streamer
module tb_sort_result_streamer;
   typedef struct {
      logic [7:0] d;
      logic [2:0] i;
      logic       l;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       done1 = 1'b0, done2 = 1'b0;
   logic       clr1 = 1'b0, clr2 = 1'b0;
   logic [7:0] din1 [6];
   logic [7:0] din2 [6];
   logic [7:0] fa [6];
   logic [7:0] fb [6];
   logic       busy1, busy2, ovr1, ovr2;
   int         errors = 0;
   int         checks = 0;
   exp_t       q1[$];
   exp_t       q2[$];
   logic       p1_valid = 1'b0, p1_ready = 1'b0;
   logic [7:0] p1_data  = '0;
   logic [2:0] p1_index = '0;
   logic       p1_last  = 1'b0;

   sort_result_streamer_if #(.N(6), .WIDTH(8)) s1 ();
   sort_result_streamer_if #(.N(6), .WIDTH(8)) s2 ();

   sort_result_streamer #(.N(6), .WIDTH(8), .DESCENDING(1'b0)) dut_asc (
      .clk(clk), .rst(rst), .done_in(done1), .data_sorted_in(din1),
      .stream(s1), .busy(busy1), .overrun(ovr1), .clear_overrun(clr1));

   sort_result_streamer #(.N(6), .WIDTH(8), .DESCENDING(1'b1)) dut_desc (
      .clk(clk), .rst(rst), .done_in(done2), .data_sorted_in(din2),
      .stream(s2), .busy(busy2), .overrun(ovr2), .clear_overrun(clr2));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push1(input logic [7:0] f [6]);
      for (int k = 0; k < 6; k++) q1.push_back('{d: f[k], i: 3'(k), l: (k == 5)});
   endtask

   task automatic wait_idle1(input string tag);
      int n = 0;
      while (busy1 && n < 60) begin
         step();
         n++;
      end
      @(negedge clk);
      chk(tag, {31'd0, busy1}, 32'd0);
   endtask

   // Scoreboard and stall-stability monitors, sampled away from the active edge.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && p1_valid && !p1_ready) begin
         chk("stall_valid", {31'd0, s1.out_valid}, 32'd1);
         chk("stall_data", {24'd0, s1.out_data}, {24'd0, p1_data});
         chk("stall_index", {29'd0, s1.out_index}, {29'd0, p1_index});
         chk("stall_last", {31'd0, s1.out_last}, {31'd0, p1_last});
      end
      if (s1.out_valid && s1.out_ready) begin
         chk("sb1_nonempty", {31'd0, (q1.size() > 0)}, 32'd1);
         if (q1.size() > 0) begin
            e = q1.pop_front();
            chk("sb1_data", {24'd0, s1.out_data}, {24'd0, e.d});
            chk("sb1_index", {29'd0, s1.out_index}, {29'd0, e.i});
            chk("sb1_last", {31'd0, s1.out_last}, {31'd0, e.l});
         end
      end
      p1_valid = s1.out_valid;
      p1_ready = s1.out_ready;
      p1_data  = s1.out_data;
      p1_index = s1.out_index;
      p1_last  = s1.out_last;
   end

   always @(negedge clk) begin
      exp_t e;
      if (s2.out_valid && s2.out_ready) begin
         chk("sb2_nonempty", {31'd0, (q2.size() > 0)}, 32'd1);
         if (q2.size() > 0) begin
            e = q2.pop_front();
            chk("sb2_data", {24'd0, s2.out_data}, {24'd0, e.d});
            chk("sb2_index", {29'd0, s2.out_index}, {29'd0, e.i});
            chk("sb2_last", {31'd0, s2.out_last}, {31'd0, e.l});
         end
      end
   end

   initial begin
      bit held_low;
      fa = '{8'd3, 8'd7, 8'd9, 8'd12, 8'd40, 8'd200};
      fb = '{8'd1, 8'd1, 8'd2, 8'd2, 8'd5, 8'd8};
      din1 = fa;
      din2 = fa;
      s1.out_ready = 1'b1;
      s2.out_ready = 1'b0;

      // Reset state
      @(negedge clk);
      chk("rst_valid", {31'd0, s1.out_valid}, 32'd0);
      chk("rst_last", {31'd0, s1.out_last}, 32'd0);
      chk("rst_data", {24'd0, s1.out_data}, 32'd0);
      chk("rst_index", {29'd0, s1.out_index}, 32'd0);
      chk("rst_busy", {31'd0, busy1}, 32'd0);
      chk("rst_overrun", {31'd0, ovr1}, 32'd0);
      chk("rst_valid_desc", {31'd0, s2.out_valid}, 32'd0);
      step();
      rst = 1'b0;
      step();

      // 1: ascending frame, sustained ready, one-cycle latency, back-to-back words
      push1(fa);
      done1 = 1'b1;
      @(negedge clk);
      chk("t1_no_early_valid", {31'd0, s1.out_valid}, 32'd0);
      step();
      done1 = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("t1_valid", {31'd0, s1.out_valid}, 32'd1);
         chk("t1_index", {29'd0, s1.out_index}, k);
         step();
      end
      @(negedge clk);
      chk("t1_busy_after", {31'd0, busy1}, 32'd0);
      chk("t1_sb_drained", q1.size(), 32'd0);

      // 2: ready toggling 1,0,0 -> stalls hold every output
      step();
      push1(fa);
      done1 = 1'b1;
      step();
      done1 = 1'b0;
      for (int k = 0; k < 40 && busy1; k++) begin
         s1.out_ready = (k % 3 == 0);
         step();
      end
      s1.out_ready = 1'b1;
      wait_idle1("t2_idle");
      chk("t2_sb_drained", q1.size(), 32'd0);

      // 3: descending instance
      s2.out_ready = 1'b1;
      for (int k = 5; k >= 0; k--) q2.push_back('{d: fa[k], i: 3'(k), l: (k == 0)});
      done2 = 1'b1;
      step();
      done2 = 1'b0;
      for (int k = 0; k < 8; k++) step();
      @(negedge clk);
      chk("t3_sb_drained", q2.size(), 32'd0);
      chk("t3_busy_after", {31'd0, busy2}, 32'd0);

      // 4: second edge while word 2 presented -> dropped, overrun (set beats clear)
      step();
      push1(fa);
      done1 = 1'b1;
      step();
      done1 = 1'b0;
      step();
      step();
      din1 = fb;
      done1 = 1'b1;
      clr1 = 1'b1;
      @(negedge clk);
      chk("t4_word2_index", {29'd0, s1.out_index}, 32'd2);
      step();
      done1 = 1'b0;
      clr1 = 1'b0;
      @(negedge clk);
      chk("t4_overrun_set", {31'd0, ovr1}, 32'd1);
      wait_idle1("t4_idle");
      chk("t4_sb_drained", q1.size(), 32'd0);
      chk("t4_overrun_sticky", {31'd0, ovr1}, 32'd1);
      step();
      clr1 = 1'b1;
      @(negedge clk);
      chk("t4_overrun_before_clear", {31'd0, ovr1}, 32'd1);
      step();
      clr1 = 1'b0;
      @(negedge clk);
      chk("t4_overrun_cleared", {31'd0, ovr1}, 32'd0);

      // 5: new edge on the last transfer -> seamless chaining, no overrun
      step();
      din1 = fa;
      push1(fa);
      done1 = 1'b1;
      step();
      done1 = 1'b0;
      for (int k = 0; k < 5; k++) step();
      din1 = fb;
      push1(fb);
      done1 = 1'b1;
      @(negedge clk);
      chk("t5_last_shown", {31'd0, s1.out_last}, 32'd1);
      step();
      done1 = 1'b0;
      @(negedge clk);
      chk("t5_no_gap", {31'd0, s1.out_valid}, 32'd1);
      chk("t5_next_data", {24'd0, s1.out_data}, 32'd1);
      chk("t5_next_index", {29'd0, s1.out_index}, 32'd0);
      wait_idle1("t5_idle");
      chk("t5_no_overrun", {31'd0, ovr1}, 32'd0);
      chk("t5_sb_drained", q1.size(), 32'd0);

      // 6: asynchronous reset mid-frame abandons it
      step();
      din1 = fa;
      push1(fa);
      done1 = 1'b1;
      step();
      done1 = 1'b0;
      for (int k = 0; k < 4; k++) step();
      rst = 1'b1;
      #1;
      chk("t6_async_valid", {31'd0, s1.out_valid}, 32'd0);
      chk("t6_async_busy", {31'd0, busy1}, 32'd0);
      chk("t6_async_data", {24'd0, s1.out_data}, 32'd0);
      chk("t6_words_left", q1.size(), 32'd2);
      q1.delete();
      step();
      step();
      rst = 1'b0;
      held_low = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (s1.out_valid) held_low = 1'b0;
         step();
      end
      chk("t6_no_resume", {31'd0, held_low}, 32'd1);
      din1 = fb;
      push1(fb);
      done1 = 1'b1;
      step();
      done1 = 1'b0;
      @(negedge clk);
      chk("t6_restart_index", {29'd0, s1.out_index}, 32'd0);
      wait_idle1("t6_idle");
      chk("t6_sb_drained", q1.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
